// File: rtl/la_pkg.sv
// Shared register-map constants and read-source encoding for the logic-analyzer sample FIFO.
package la_pkg;

  localparam logic [15:0] LA_FIFO_STATUS = 16'd0;
  localparam logic [15:0] LA_FIFO_FLAGS  = 16'd1;
  localparam logic [15:0] LA_FIFO_CTRL   = 16'd2;
  localparam logic [15:0] LA_FIFO_DATA   = 16'd3;

  localparam int LA_FLAG_EMPTY    = 0;
  localparam int LA_FLAG_FULL     = 1;
  localparam int LA_FLAG_OVERFLOW = 2;

  // Which registered source feeds rdata_o in the cycle after a bus read.
  typedef enum logic [1:0] {
    LA_RD_PASS = 2'd0,
    LA_RD_REG  = 2'd1,
    LA_RD_RAM  = 2'd2
  } la_rd_src_e;

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, read-first.
// Read data appears one cycle after the address; no reset on contents or read register.
module la_sample_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_dat,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_dat;

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
    r_rd_dat <= r_mem[i_rd_addr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/la_sample_fifo.sv
// Circular capture buffer behind the LA capture FSM, readable oldest-first over the daisy-chained 16-bit bus.
// Bus read latency 1 cycle; LA_SAMPLE_FIFO_OVERFLOW_EN adds a sticky overflow flag at FLAGS bit2.
module la_sample_fifo
  import la_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          SAMPLE_DEPTH = 1024,
  parameter int          SAMPLE_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SAMPLE_WIDTH-1:0]         probe,
  input  logic                            acquire,
  input  logic                            pop,
  output logic [$clog2(SAMPLE_DEPTH):0]   size,
  input  logic [15:0]                     addr_i,
  input  logic [15:0]                     wdata_i,
  input  logic [15:0]                     rdata_i,
  input  logic                            rw_i,
  input  logic                            valid_i,
  output logic [15:0]                     addr_o,
  output logic [15:0]                     wdata_o,
  output logic [15:0]                     rdata_o,
  output logic                            rw_o,
  output logic                            valid_o
);

  localparam int AW         = $clog2(SAMPLE_DEPTH);
  localparam int SW         = AW + 1;
  localparam int OWNED_SPAN = 3 + SAMPLE_DEPTH;

  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [SW-1:0]           r_size;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_ovf;
  logic                    w_clear;
  logic                    w_do_wr;
  logic                    w_do_pop;

  logic [16:0]             w_off_ext;
  logic [15:0]             w_off;
  logic                    w_owned;
  logic                    w_bus_rd;
  logic                    w_bus_wr;
  logic [AW-1:0]           w_ram_raddr;
  logic [SAMPLE_WIDTH-1:0] w_ram_dat;
  logic [15:0]             w_reg_dat;
  logic                    w_unused;

  la_rd_src_e              r_rd_src;
  logic [15:0]             r_rdata_pass;
  logic [15:0]             r_reg_dat;

  assign w_full  = (r_size == SW'(SAMPLE_DEPTH));
  assign w_empty = (r_size == '0);

  // Below-base addresses wrap to a huge 17-bit offset and so fall outside the span.
  assign w_off_ext = {1'b0, addr_i} - {1'b0, BASE_ADDR};
  assign w_off     = w_off_ext[15:0];
  assign w_owned   = (w_off_ext < 17'(OWNED_SPAN));
  assign w_bus_rd  = valid_i && !rw_i && w_owned;
  assign w_bus_wr  = valid_i && rw_i && w_owned;
  assign w_clear   = w_bus_wr && (w_off == LA_FIFO_CTRL) && wdata_i[0];
  assign w_unused  = ^wdata_i[15:1];

  assign w_do_wr  = !rst && !w_clear && acquire && (!w_full || pop);
  assign w_do_pop = !w_clear && pop && !w_empty;

  assign w_ram_raddr = r_rd_ptr + AW'(w_off - LA_FIFO_DATA);

  la_sample_ram #(
    .DEPTH (SAMPLE_DEPTH),
    .WIDTH (SAMPLE_WIDTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_do_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_dat  (probe),
    .i_rd_addr (w_ram_raddr),
    .o_rd_dat  (w_ram_dat)
  );

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_size   <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_wr && !w_do_pop) begin
        r_size <= r_size + SW'(1);
      end else if (w_do_pop && !w_do_wr) begin
        r_size <= r_size - SW'(1);
      end
    end
  end

  assign size = r_size;

`ifdef LA_SAMPLE_FIFO_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_overflow <= 1'b0;
    end else if (acquire && !pop && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign w_ovf = r_overflow;
`else
  assign w_ovf = 1'b0;
`endif

  always_comb begin
    w_reg_dat = '0;
    if (w_off == LA_FIFO_STATUS) begin
      w_reg_dat = 16'(r_size);
    end else if (w_off == LA_FIFO_FLAGS) begin
      w_reg_dat[LA_FLAG_EMPTY]    = w_empty;
      w_reg_dat[LA_FLAG_FULL]     = w_full;
      w_reg_dat[LA_FLAG_OVERFLOW] = w_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_o       <= '0;
      wdata_o      <= '0;
      rw_o         <= 1'b0;
      valid_o      <= 1'b0;
      r_rdata_pass <= '0;
      r_reg_dat    <= '0;
      r_rd_src     <= LA_RD_PASS;
    end else begin
      addr_o       <= addr_i;
      wdata_o      <= wdata_i;
      rw_o         <= rw_i;
      valid_o      <= valid_i;
      r_rdata_pass <= rdata_i;
      r_reg_dat    <= w_reg_dat;
      if (!w_bus_rd) begin
        r_rd_src <= LA_RD_PASS;
      end else if (w_off >= LA_FIFO_DATA) begin
        r_rd_src <= LA_RD_RAM;
      end else begin
        r_rd_src <= LA_RD_REG;
      end
    end
  end

  // RAM read register is already aligned with the other bus registers, so only a mux follows.
  always_comb begin
    rdata_o = r_rdata_pass;
    case (r_rd_src)
      LA_RD_REG: rdata_o = r_reg_dat;
      LA_RD_RAM: rdata_o = 16'(w_ram_dat);
      default:   rdata_o = r_rdata_pass;
    endcase
  end

endmodule

// File: tb/tb_la_sample_fifo.sv
// Self-checking bench for la_sample_fifo: directed scenarios then random traffic against a queue model.
module tb_la_sample_fifo;

  localparam int          D    = 8;
  localparam int          W    = 12;
  localparam logic [15:0] BASE = 16'h0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [W-1:0] probe;
  logic        acquire;
  logic        pop;
  logic [3:0]  size;
  logic [15:0] addr_i, wdata_i, rdata_i;
  logic        rw_i, valid_i;
  logic [15:0] addr_o, wdata_o, rdata_o;
  logic        rw_o, valid_o;

  always #5 clk = ~clk;

  la_sample_fifo #(
    .BASE_ADDR    (BASE),
    .SAMPLE_DEPTH (D),
    .SAMPLE_WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .probe   (probe),
    .acquire (acquire),
    .pop     (pop),
    .size    (size),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_i (rdata_i),
    .rw_i    (rw_i),
    .valid_i (valid_i),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .rdata_o (rdata_o),
    .rw_o    (rw_o),
    .valid_o (valid_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int q[$];
  bit m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int flags_now();
    int f;
    f = 0;
    if (q.size() == 0) f |= 1;
    if (q.size() == D) f |= 2;
`ifdef LA_SAMPLE_FIFO_OVERFLOW_EN
    if (m_ovf) f |= 4;
`endif
    return f;
  endfunction

  // One clock cycle: drive at negedge, model the edge, check outputs at the next negedge.
  task automatic step(input bit r, input bit acq, input bit pp, input int pr,
                      input bit bv, input bit brw, input logic [15:0] ba,
                      input logic [15:0] bwd, input logic [15:0] brd);
    int  off;
    int  exp_rd;
    bit  chk_rd;
    bit  clr;
    bit  full;
    int  pv;
    pv = pr & ((1 << W) - 1);
    rst = r; acquire = acq; pop = pp; probe = pv[W-1:0];
    valid_i = bv; rw_i = brw; addr_i = ba; wdata_i = bwd; rdata_i = brd;

    off    = int'(ba) - int'(BASE);
    chk_rd = 1'b1;
    exp_rd = int'(brd);
    if (bv && !brw && off >= 0 && off < 3 + D) begin
      if (off == 0)                exp_rd = q.size();
      else if (off == 1)           exp_rd = flags_now();
      else if (off == 2)           chk_rd = 1'b0;
      else if (off - 3 < q.size()) exp_rd = q[off - 3];
      else                         chk_rd = 1'b0;
    end
    clr = bv && brw && (off == 2) && bwd[0];

    @(posedge clk);
    if (r || clr) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      full = (q.size() == D);
      if (acq && !pp && full) m_ovf = 1'b1;
      if (pp && q.size() > 0) void'(q.pop_front());
      if (acq && (!full || pp)) q.push_back(pv);
    end

    @(negedge clk);
    check("size", 32'(size), q.size());
    if (r) begin
      check("rst_addr_o", addr_o, 0);
      check("rst_wdata_o", wdata_o, 0);
      check("rst_rdata_o", rdata_o, 0);
      check("rst_rw_o", 32'(rw_o), 0);
      check("rst_valid_o", 32'(valid_o), 0);
    end else begin
      check("addr_o", addr_o, ba);
      check("wdata_o", wdata_o, bwd);
      check("rw_o", 32'(rw_o), brw);
      check("valid_o", 32'(valid_o), bv);
      if (chk_rd) check($sformatf("rdata_o@%0h", ba), rdata_o, exp_rd);
    end
  endtask

  task automatic cap(input bit acq, input bit pp, input int pr);
    step(1'b0, acq, pp, pr, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic rd(input logic [15:0] ba, input logic [15:0] brd);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, ba, 16'h0, brd);
  endtask

  task automatic do_rst();
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 16'h1234, 16'h5678, 16'h9ABC);
  endtask

  initial begin
    rst = 1'b1; acquire = 1'b0; pop = 1'b0; probe = '0;
    valid_i = 1'b0; rw_i = 1'b0; addr_i = '0; wdata_i = '0; rdata_i = '0;
    @(negedge clk);
    do_rst();

    // Basic capture and oldest-first readout.
    for (int i = 1; i <= 5; i++) cap(1'b1, 1'b0, i);
    for (int k = 0; k < 5; k++) rd(BASE + 16'(3 + k), 16'hFFFF);
    rd(BASE + 16'd1, 16'h0);
    rd(BASE + 16'd0, 16'h0);

    // Overfill: drops beyond depth.
    do_rst();
    for (int i = 1; i <= 10; i++) cap(1'b1, 1'b0, i);
    rd(BASE + 16'd0, 16'h0);
    rd(BASE + 16'd1, 16'h0);
    for (int k = 0; k < D; k++) rd(BASE + 16'(3 + k), 16'h0);

    // Sliding window with wrap.
    do_rst();
    for (int i = 1; i <= 8; i++) cap(1'b1, 1'b0, i);
    for (int i = 9; i <= 11; i++) cap(1'b1, 1'b1, i);
    for (int k = 0; k < D; k++) rd(BASE + 16'(3 + k), 16'h0);
    rd(BASE + 16'd1, 16'h0);

    // Pop from empty is ignored.
    do_rst();
    for (int i = 0; i < 4; i++) cap(1'b0, 1'b1, 0);
    cap(1'b1, 1'b0, 'hA);
    rd(BASE + 16'd3, 16'h0);
    cap(1'b1, 1'b1, 'h5);
    rd(BASE + 16'd3, 16'h0);

    // Reset and CTRL clear mid-capture.
    do_rst();
    for (int i = 1; i <= 6; i++) cap(1'b1, 1'b0, i);
    step(1'b1, 1'b1, 1'b0, 7, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int i = 1; i <= 6; i++) cap(1'b1, 1'b0, i);
    step(1'b0, 1'b1, 1'b0, 7, 1'b1, 1'b1, BASE + 16'd2, 16'h0000, 16'h0);
    step(1'b0, 1'b1, 1'b0, 8, 1'b1, 1'b1, BASE + 16'd2, 16'h0001, 16'h0);
    step(1'b0, 1'b1, 1'b0, 9, 1'b1, 1'b1, BASE + 16'd0, 16'hFFFF, 16'h0);
    rd(BASE + 16'd3, 16'h0);

    // Pass-through of unowned and neighbouring addresses.
    rd(BASE + 16'd20, 16'hBEEF);
    rd(BASE + 16'd0, 16'hBEEF);
    rd(BASE - 16'd1, 16'h1357);
    rd(BASE + 16'(3 + D), 16'h2468);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r, acq, pp, bv, brw;
      logic [15:0] ba, bwd, brd;
      r   = ($urandom % 600) == 0;
      acq = ($urandom % 3) != 0;
      pp  = (i < 1500) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
      bv  = $urandom % 2;
      brw = ($urandom % 4) == 0;
      ba  = BASE - 16'd2 + 16'($urandom % 17);
      bwd = 16'($urandom);
      brd = 16'($urandom);
      if (ba == BASE + 16'd2 && brw) bwd[0] = ($urandom % 40) == 0;
      step(r, acq, pp, int'($urandom), bv, brw, ba, bwd, brd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
